// File: rtl/toe_cam_pkg.sv
// Shared parameters, entry field positions and sweep FSM encoding for the
// TOE CAM ager.
package toe_cam_pkg;

  localparam int TOE_A = 14;
  localparam int TOE_C = 2;
  localparam int TOE_D = 112;
  localparam int TOE_K = 96;
  localparam int TOE_V = 14;
  localparam int TOE_U = 10;

  localparam int KEY_LSB   = 0;
  localparam int VAL_LSB   = 96;
  localparam int VALID_BIT = 111;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_REQ,
    ST_RD_WAIT,
    ST_EVAL,
    ST_WR_REQ,
    ST_NEXT,
    ST_EPOCH_WAIT
  } ager_state_e;

endpackage

// File: rtl/toe_cam_epoch.sv
// Free-running epoch counter and one-hot aging timestamp. The timestamp only
// moves when the sweep FSM asks it to via advance.
module toe_cam_epoch
  import toe_cam_pkg::*;
#(
  parameter int U = TOE_U
) (
  input  logic         Clk,
  input  logic         Rst_n,
  input  logic [31:0]  epoch_cycles,
  input  logic         advance,
  output logic         epoch_sat,
  output logic [U-1:0] aging_ts
);

  logic [31:0] cnt;
  logic [31:0] limit;

  // A zero-cycle epoch behaves as a one-cycle epoch.
  assign limit     = (epoch_cycles == 32'd0) ? 32'd0 : epoch_cycles - 32'd1;
  assign epoch_sat = (cnt >= limit);

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      cnt      <= 32'd0;
      aging_ts <= {{(U-1){1'b0}}, 1'b1};
    end else if (advance) begin
      cnt      <= 32'd0;
      aging_ts <= {aging_ts[U-2:0], aging_ts[U-1]};
    end else if (!epoch_sat) begin
      cnt      <= cnt + 32'd1;
    end
  end

endmodule

// File: rtl/toe_cam_ager.sv
// Background ager: sweeps every BRAM then CAM entry once per epoch and deletes
// entries whose used stamp shows no hit for a full timestamp revolution.
module toe_cam_ager
  import toe_cam_pkg::*;
#(
  parameter int A = TOE_A,
  parameter int C = TOE_C,
  parameter int D = TOE_D,
  parameter int K = TOE_K,
  parameter int V = TOE_V,
  parameter int U = TOE_U
) (
  input  logic         Clk,
  input  logic         Rst_n,
  input  logic         Enable,
  input  logic [31:0]  EpochCycles,
  output logic [U-1:0] AgingTimestamp,
  output logic         RamReqValid,
  output logic         RamReqOp,
  output logic [A:0]   RamRwAddr,
  output logic [D-1:0] RamWrData,
  output logic [U-1:0] RamWrUsed,
  input  logic         RamReqGrant,
  input  logic [D-1:0] RamRdData,
  input  logic [U-1:0] RamRdUsed,
  input  logic         LookupRespValid,
  input  logic         LookupRespHit,
  input  logic [K-1:0] LookupRespKey,
  output logic         AgedValid,
  output logic [K-1:0] AgedKey,
  output logic [V-1:0] AgedValue,
  output logic [15:0]  DeleteCount
);

  // Delete writes keep key and value only; valid and spare bits go out as 0.
  localparam logic [D-1:0] KEEP_MASK = {{(D-K-V){1'b0}}, {(K+V){1'b1}}};
  localparam logic [A:0]   PTR_ONE   = (A+1)'(1);
  localparam logic [A:0]   CAM_BASE  = {1'b1, {A{1'b0}}};

  ager_state_e  state;
  logic [A:0]   ptr;
  logic         sweep_done;
  logic [D-1:0] cap_data;
  logic [U-1:0] cap_used;
  logic         req_valid;
  logic         req_op;
  logic [D-1:0] wr_data;
  logic [U-1:0] wr_used;
  logic         aged_valid;
  logic [K-1:0] aged_key;
  logic [V-1:0] aged_val;
  logic [15:0]  del_cnt;

  logic         epoch_sat;
  logic         advance;
  logic [U-1:0] next_ts;
  logic         stale;
  logic         snoop_hit;
  logic         abort_rd;
  logic         abort_cap;
  logic         last_loc;

  assign advance = (state == ST_EPOCH_WAIT) && epoch_sat;

  toe_cam_epoch #(.U(U)) u_epoch (
    .Clk          (Clk),
    .Rst_n        (Rst_n),
    .epoch_cycles (EpochCycles),
    .advance      (advance),
    .epoch_sat    (epoch_sat),
    .aging_ts     (AgingTimestamp)
  );

  assign next_ts = {AgingTimestamp[U-2:0], AgingTimestamp[U-1]};
  assign stale   = cap_data[VALID_BIT] &
                   (((~cap_used) == next_ts) | (&cap_used));

  // A lookup hit on the entry under evaluation means it is live; back off.
  // In RD_WAIT the key is still on the read bus, afterwards it is captured.
  assign snoop_hit = LookupRespValid & LookupRespHit;
  assign abort_rd  = snoop_hit & (LookupRespKey == RamRdData[KEY_LSB +: K]);
  assign abort_cap = snoop_hit & (LookupRespKey == cap_data[KEY_LSB +: K]);

  assign last_loc  = ptr[A] & (&ptr[C-1:0]);

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state      <= ST_IDLE;
      ptr        <= '0;
      sweep_done <= 1'b0;
      cap_data   <= '0;
      cap_used   <= '0;
      req_valid  <= 1'b0;
      req_op     <= 1'b0;
      wr_data    <= '0;
      wr_used    <= '0;
      aged_valid <= 1'b0;
      aged_key   <= '0;
      aged_val   <= '0;
      del_cnt    <= '0;
    end else begin
      aged_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (Enable && !sweep_done) begin
            req_valid <= 1'b1;
            req_op    <= 1'b0;
            state     <= ST_RD_REQ;
          end
        end
        ST_RD_REQ: begin
          if (RamReqGrant) begin
            req_valid <= 1'b0;
            state     <= ST_RD_WAIT;
          end
        end
        ST_RD_WAIT: begin
          cap_data <= RamRdData;
          cap_used <= RamRdUsed;
          state    <= abort_rd ? ST_NEXT : ST_EVAL;
        end
        ST_EVAL: begin
          if (!abort_cap && stale) begin
            req_valid <= 1'b1;
            req_op    <= 1'b1;
            wr_data   <= cap_data & KEEP_MASK;
            wr_used   <= '1;
            state     <= ST_WR_REQ;
          end else begin
            state     <= ST_NEXT;
          end
        end
        ST_WR_REQ: begin
          // Once granted the write has left; a same-cycle hit cannot recall it.
          if (RamReqGrant) begin
            req_valid  <= 1'b0;
            aged_valid <= 1'b1;
            aged_key   <= cap_data[KEY_LSB +: K];
            aged_val   <= cap_data[VAL_LSB +: V];
            if (del_cnt != 16'hFFFF) del_cnt <= del_cnt + 16'd1;
            state      <= ST_NEXT;
          end else if (abort_cap) begin
            req_valid  <= 1'b0;
            state      <= ST_NEXT;
          end
        end
        ST_NEXT: begin
          if (last_loc) begin
            ptr        <= '0;
            sweep_done <= 1'b1;
            state      <= ST_EPOCH_WAIT;
          end else begin
            ptr        <= (!ptr[A] && (&ptr[A-1:0])) ? CAM_BASE : ptr + PTR_ONE;
            state      <= ST_IDLE;
          end
        end
        ST_EPOCH_WAIT: begin
          if (epoch_sat) begin
            sweep_done <= 1'b0;
            state      <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign RamReqValid = req_valid;
  assign RamReqOp    = req_op;
  assign RamRwAddr   = ptr;
  assign RamWrData   = wr_data;
  assign RamWrUsed   = wr_used;
  assign AgedValid   = aged_valid;
  assign AgedKey     = aged_key;
  assign AgedValue   = aged_val;
  assign DeleteCount = del_cnt;

endmodule

// File: tb/tb_toe_cam_ager.sv
// Bench for toe_cam_ager: small-BRAM instance, behavioural RAM + arbiter,
// table vectors, hand corner sequences and randomized sweeps vs a model.
module tb_toe_cam_ager;
  import toe_cam_pkg::*;

  localparam int A = 4, C = 2, D = 112, K = 96, V = 14, U = 10;
  localparam int NB = 1 << A, NC = 1 << C, NLOC = NB + NC;

  logic         Clk = 1'b0;
  logic         Rst_n;
  logic         Enable;
  logic [31:0]  EpochCycles;
  logic [U-1:0] AgingTimestamp;
  logic         RamReqValid, RamReqOp;
  logic [A:0]   RamRwAddr;
  logic [D-1:0] RamWrData;
  logic [U-1:0] RamWrUsed;
  logic         RamReqGrant;
  logic [D-1:0] RamRdData;
  logic [U-1:0] RamRdUsed;
  logic         LookupRespValid, LookupRespHit;
  logic [K-1:0] LookupRespKey;
  logic         AgedValid;
  logic [K-1:0] AgedKey;
  logic [V-1:0] AgedValue;
  logic [15:0]  DeleteCount;

  always #5 Clk = ~Clk;

  toe_cam_ager #(.A(A), .C(C), .D(D), .K(K), .V(V), .U(U)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .Enable(Enable), .EpochCycles(EpochCycles),
    .AgingTimestamp(AgingTimestamp), .RamReqValid(RamReqValid),
    .RamReqOp(RamReqOp), .RamRwAddr(RamRwAddr), .RamWrData(RamWrData),
    .RamWrUsed(RamWrUsed), .RamReqGrant(RamReqGrant), .RamRdData(RamRdData),
    .RamRdUsed(RamRdUsed), .LookupRespValid(LookupRespValid),
    .LookupRespHit(LookupRespHit), .LookupRespKey(LookupRespKey),
    .AgedValid(AgedValid), .AgedKey(AgedKey), .AgedValue(AgedValue),
    .DeleteCount(DeleteCount)
  );

  typedef struct {
    int           idx;
    bit           valid;
    logic [U-1:0] used;
    bit           abort;
    int           exp_del;
  } vec_t;

  int n_chk = 0, n_fail = 0;
  logic [D-1:0] mem_d [NLOC];
  logic [U-1:0] mem_u [NLOC];
  logic [D-1:0] exp_d [NLOC];
  logic [U-1:0] exp_u [NLOC];
  int reads, writes, grant_mode, hold_cnt, inj_cnt, inj_idx;
  bit stable, inj_en, noise_en, ts_early;
  logic [A:0]   wr_addr, h_addr;
  logic [D-1:0] h_data;
  logic [U-1:0] h_used;
  logic [K-1:0] inj_key;
  int           rd_seq [$];
  logic [K-1:0] aged_k [$];
  logic [V-1:0] aged_v [$];
  logic [K-1:0] exp_k [$];
  logic [V-1:0] exp_v [$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int addr2idx(input logic [A:0] a);
    return a[A] ? NB + int'(a[C-1:0]) : int'(a[A-1:0]);
  endfunction

  function automatic logic [A:0] idx2addr(input int i);
    return (i < NB) ? (A+1)'(i) : (A+1)'(NB + (i - NB));
  endfunction

  function automatic logic [K-1:0] rkey();
    return {$urandom, $urandom, $urandom};
  endfunction

  // Reference aging rule: entry dies if valid and its used stamp is either the
  // "never hit" marker or the complement of the next epoch's one-hot.
  function automatic bit model_stale(input logic [D-1:0] d, input logic [U-1:0] u, input int epoch);
    logic [U-1:0] nts;
    nts = U'(1) << ((epoch + 1) % U);
    return d[D-1] && ((~u == nts) || (u == {U{1'b1}}));
  endfunction

  // One clock: choose grant, let the edge happen, then play RAM/arbiter.
  task automatic cycle();
    logic xfer, op; logic [A:0] ad; logic [D-1:0] wd; logic [U-1:0] wu; int ix;
    case (grant_mode)
      0: RamReqGrant = 1'b1;
      1: RamReqGrant = ($urandom_range(0, 3) != 0);
      2: begin
        RamReqGrant = 1'b1;
        if (RamReqValid && RamReqOp && hold_cnt < 20) begin
          if (hold_cnt == 0) begin
            h_addr = RamRwAddr; h_data = RamWrData; h_used = RamWrUsed;
          end else if (RamRwAddr !== h_addr || RamWrData !== h_data || RamWrUsed !== h_used)
            stable = 1'b0;
          hold_cnt++;
          RamReqGrant = 1'b0;
        end
      end
      default: RamReqGrant = 1'b0;
    endcase
    xfer = RamReqValid && RamReqGrant;
    op = RamReqOp; ad = RamRwAddr; wd = RamWrData; wu = RamWrUsed;
    @(posedge Clk); #1;
    RamRdData = '0; RamRdUsed = '0;
    if (inj_cnt == 2) begin
      LookupRespValid = 1'b0; LookupRespHit = 1'b0; inj_cnt = 0;
    end else if (inj_cnt == 1) begin
      LookupRespValid = 1'b1; LookupRespHit = 1'b1; LookupRespKey = inj_key; inj_cnt = 2;
    end else if (noise_en) begin
      LookupRespValid = 1'($urandom); LookupRespHit = 1'($urandom); LookupRespKey = rkey();
    end
    if (xfer) begin
      ix = addr2idx(ad);
      if (!op) begin
        reads++; rd_seq.push_back(ix);
        RamRdData = mem_d[ix]; RamRdUsed = mem_u[ix];
        if (inj_en && ix == inj_idx) begin inj_cnt = 1; inj_key = mem_d[ix][K-1:0]; end
      end else begin
        writes++; wr_addr = ad; mem_d[ix] = wd; mem_u[ix] = wu;
      end
    end
    if (AgedValid) begin aged_k.push_back(AgedKey); aged_v.push_back(AgedValue); end
  endtask

  task automatic do_reset();
    Rst_n = 1'b0; Enable = 1'b0; RamReqGrant = 1'b0;
    LookupRespValid = 1'b0; LookupRespHit = 1'b0; LookupRespKey = '0;
    RamRdData = '0; RamRdUsed = '0;
    reads = 0; writes = 0; hold_cnt = 0; inj_cnt = 0; stable = 1'b1;
    inj_en = 1'b0; noise_en = 1'b0; ts_early = 1'b0; grant_mode = 0;
    rd_seq.delete(); aged_k.delete(); aged_v.delete();
    @(posedge Clk); @(posedge Clk); #1;
    Rst_n = 1'b1;
  endtask

  task automatic fill_invalid();
    for (int i = 0; i < NLOC; i++) begin
      mem_d[i] = {1'b0, 1'($urandom), V'($urandom), rkey()};
      mem_u[i] = U'($urandom);
    end
  endtask

  task automatic run_sweep(input string tag);
    int guard = 0;
    Enable = 1'b1;
    while (reads < NLOC && guard < 3000) begin
      cycle(); guard++;
      if (reads < NLOC && AgingTimestamp !== U'(1)) ts_early = 1'b1;
    end
    check({tag, "_sweep_done"}, reads >= NLOC, 1);
    repeat (40) cycle();
  endtask

  initial begin
    vec_t vecs [10];
    logic [K-1:0] key; logic [V-1:0] val; logic [D-1:0] orig;
    int errs, nexp, guard;

    vecs[0] = '{5,        1'b1, 10'h3FD, 1'b0, 1};
    vecs[1] = '{5,        1'b1, 10'h3FF, 1'b0, 1};
    vecs[2] = '{5,        1'b0, 10'h3FF, 1'b0, 0};
    vecs[3] = '{5,        1'b1, 10'h001, 1'b0, 0};
    vecs[4] = '{5,        1'b1, 10'h3FE, 1'b0, 0};
    vecs[5] = '{NB + 2,   1'b1, 10'h3FF, 1'b0, 1};
    vecs[6] = '{0,        1'b1, 10'h3FD, 1'b0, 1};
    vecs[7] = '{NLOC - 1, 1'b1, 10'h3FD, 1'b0, 1};
    vecs[8] = '{15,       1'b1, 10'h000, 1'b0, 0};
    vecs[9] = '{5,        1'b1, 10'h3FD, 1'b1, 0};

    // Reset state
    Rst_n = 1'b1; Enable = 1'b0; EpochCycles = 32'd5000;
    RamReqGrant = 1'b0; LookupRespValid = 1'b0; LookupRespHit = 1'b0;
    LookupRespKey = '0; RamRdData = '0; RamRdUsed = '0;
    #2 Rst_n = 1'b0;
    #1;
    check("rst_ts", AgingTimestamp, 1);
    check("rst_req_valid", RamReqValid, 0);
    check("rst_aged_valid", AgedValid, 0);
    check("rst_aged_key", AgedKey, 0);
    check("rst_aged_value", AgedValue, 0);
    check("rst_delete_count", DeleteCount, 0);

    // Table: one candidate entry per sweep, everything else invalid
    for (int v = 0; v < 10; v++) begin
      do_reset();
      EpochCycles = 32'd5000;
      fill_invalid();
      key = rkey(); val = V'($urandom);
      orig = {vecs[v].valid, 1'b1, val, key};
      mem_d[vecs[v].idx] = orig;
      mem_u[vecs[v].idx] = vecs[v].used;
      inj_en = vecs[v].abort; inj_idx = vecs[v].idx;
      run_sweep($sformatf("vec%0d", v));
      check($sformatf("vec%0d_writes", v), writes, vecs[v].exp_del);
      check($sformatf("vec%0d_aged_pulses", v), aged_k.size(), vecs[v].exp_del);
      check($sformatf("vec%0d_delete_count", v), DeleteCount, vecs[v].exp_del);
      if (vecs[v].exp_del != 0) begin
        check($sformatf("vec%0d_wr_addr", v), wr_addr, idx2addr(vecs[v].idx));
        check($sformatf("vec%0d_wr_data", v), mem_d[vecs[v].idx], {2'b00, val, key});
        check($sformatf("vec%0d_wr_used", v), mem_u[vecs[v].idx], 10'h3FF);
        if (aged_k.size() > 0) begin
          check($sformatf("vec%0d_aged_key", v), aged_k[0], key);
          check($sformatf("vec%0d_aged_value", v), aged_v[0], val);
        end
      end else begin
        check($sformatf("vec%0d_entry_kept", v), mem_d[vecs[v].idx], orig);
      end
    end

    // CAM location 2 must be addressed with the CAM select bit set
    check("cam2_addr_literal", idx2addr(NB + 2), {1'b1, 4'h2});

    // Full sweep of invalid entries: order, read count, timestamp timing
    do_reset();
    EpochCycles = 32'd300;
    fill_invalid();
    run_sweep("order");
    errs = 0;
    for (int i = 0; i < NLOC; i++) if (rd_seq[i] != i) errs++;
    check("sweep_order_errors", errs, 0);
    check("sweep_reads", reads, NLOC);
    check("sweep_no_writes", writes, 0);
    check("ts_held_after_sweep", AgingTimestamp, 1);
    guard = 0;
    while (AgingTimestamp === U'(1) && guard < 600) begin cycle(); guard++; end
    check("ts_after_epoch", AgingTimestamp, 2);
    check("ts_epoch_timing", (reads == NLOC), 1);

    // EpochCycles=0: timestamp still waits for the sweep to finish
    do_reset();
    EpochCycles = 32'd0;
    fill_invalid();
    run_sweep("ep0");
    check("ep0_ts_not_early", ts_early, 0);
    check("ep0_ts_advanced", AgingTimestamp, 2);

    // Write held off by arbiter for 20 cycles
    do_reset();
    EpochCycles = 32'd5000;
    fill_invalid();
    mem_d[5] = {1'b1, 1'b0, V'($urandom), rkey()};
    mem_u[5] = 10'h3FD;
    grant_mode = 2;
    run_sweep("hold");
    check("hold_cycles", hold_cnt, 20);
    check("hold_stable", stable, 1);
    check("hold_single_write", writes, 1);
    check("hold_aged", aged_k.size(), 1);

    // Randomized sweeps against the model, random grants and lookup noise
    for (int r = 0; r < 4; r++) begin
      do_reset();
      EpochCycles = 32'd5000;
      grant_mode = 1; noise_en = 1'b1;
      exp_k.delete(); exp_v.delete();
      for (int i = 0; i < NLOC; i++) begin
        mem_d[i] = {1'($urandom), 1'($urandom), V'($urandom), rkey()};
        case ($urandom_range(0, 3))
          0: mem_u[i] = 10'h3FD;
          1: mem_u[i] = 10'h3FF;
          2: mem_u[i] = 10'h001;
          default: mem_u[i] = U'($urandom);
        endcase
        exp_d[i] = mem_d[i]; exp_u[i] = mem_u[i];
        if (model_stale(mem_d[i], mem_u[i], 0)) begin
          exp_d[i] = {2'b00, mem_d[i][K+V-1:0]};
          exp_u[i] = '1;
          exp_k.push_back(mem_d[i][K-1:0]);
          exp_v.push_back(mem_d[i][K +: V]);
        end
      end
      nexp = exp_k.size();
      run_sweep($sformatf("rnd%0d", r));
      check($sformatf("rnd%0d_writes", r), writes, nexp);
      check($sformatf("rnd%0d_delete_count", r), DeleteCount, nexp);
      check($sformatf("rnd%0d_aged_count", r), aged_k.size(), nexp);
      errs = 0;
      for (int i = 0; i < NLOC; i++)
        if (mem_d[i] !== exp_d[i] || mem_u[i] !== exp_u[i]) errs++;
      for (int i = 0; i < nexp && i < aged_k.size(); i++)
        if (aged_k[i] !== exp_k[i] || aged_v[i] !== exp_v[i]) errs++;
      check($sformatf("rnd%0d_content_errors", r), errs, 0);
    end

    // Reset asserted while a read request is pending
    do_reset();
    EpochCycles = 32'd5000;
    fill_invalid();
    Enable = 1'b1;
    guard = 0;
    while (reads < 3 && guard < 200) begin cycle(); guard++; end
    grant_mode = 3;
    repeat (4) cycle();
    check("prerst_req_pending", RamReqValid, 1);
    #2 Rst_n = 1'b0;
    #1;
    check("midrst_req_dropped", RamReqValid, 0);
    reads = 0; rd_seq.delete();
    @(posedge Clk); #1;
    Rst_n = 1'b1;
    grant_mode = 0;
    guard = 0;
    while (reads < 2 && guard < 200) begin cycle(); guard++; end
    check("restart_reads", reads >= 2, 1);
    if (rd_seq.size() >= 2) begin
      check("restart_addr0", rd_seq[0], 0);
      check("restart_addr1", rd_seq[1], 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, expected end of test");
    $fatal(1, "watchdog");
  end

endmodule
